// File: rtl/acq_sequencer.sv
// Sequencer for one lidar accumulation run: arm, skip mirror-start samples,
// step the accumulator through every range bin of each pulse, then hand off to readout.
module acq_sequencer #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      UR_CMD,
  input  logic [CNT_W-1:0] UR_MirrorStart,
  input  logic [CNT_W-1:0] UR_nRangeBins,
  input  logic [CNT_W-1:0] UR_nPoints_RB,
  input  logic [CNT_W-1:0] UR_nACC_Pulses,
  input  logic             trig_det,
  input  logic             rd_done,
  output logic             CMD_Update_Disable,
  output logic             busy,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             first_pulse,
  output logic [IDX_W-1:0] rb_index,
  output logic [IDX_W-1:0] pt_index,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             acc_done,
  output logic             trig_overrun,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SKIP,
    S_ACQ,
    S_PEND,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             start_q;
  logic [CNT_W-1:0] skip_cnt_q;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic [IDX_W-1:0] rb_q;
  logic [IDX_W-1:0] pt_q;
  logic             upd_dis_q;
  logic             busy_q;
  logic             acc_clear_q;
  logic             acc_en_q;
  logic             first_q;
  logic             acc_done_q;
  logic             overrun_q;
  logic             cfg_err_q;

  logic start_evt;
  logic abort;
  logic cfg_ok;
  logic pt_last;
  logic rb_last;

  assign start_evt = UR_CMD[0] & ~start_q;
  assign abort     = UR_CMD[1];
  assign cfg_ok    = (UR_nRangeBins != '0) && (UR_nPoints_RB != '0) && (UR_nACC_Pulses != '0);
  assign pt_last   = (CNT_W'(pt_q) == UR_nPoints_RB - CNT_ONE);
  assign rb_last   = (CNT_W'(rb_q) == UR_nRangeBins - CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      skip_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      rb_q        <= '0;
      pt_q        <= '0;
      upd_dis_q   <= 1'b0;
      busy_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_en_q    <= 1'b0;
      first_q     <= 1'b0;
      acc_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      start_q     <= UR_CMD[0];
      acc_clear_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      // Abort outranks every other event; the sticky overrun flag survives it.
      if (abort && (state_q != S_IDLE)) begin
        state_q     <= S_IDLE;
        skip_cnt_q  <= '0;
        pulse_cnt_q <= '0;
        rb_q        <= '0;
        pt_q        <= '0;
        upd_dis_q   <= 1'b0;
        busy_q      <= 1'b0;
        acc_en_q    <= 1'b0;
        first_q     <= 1'b0;
        acc_done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_evt) begin
              if (cfg_ok) begin
                state_q     <= S_ARM;
                upd_dis_q   <= 1'b1;
                busy_q      <= 1'b1;
                acc_clear_q <= 1'b1;
                pulse_cnt_q <= '0;
                overrun_q   <= 1'b0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_ARM: begin
            if (trig_det) begin
              skip_cnt_q <= UR_MirrorStart;
              if (UR_MirrorStart == '0) begin
                state_q  <= S_ACQ;
                acc_en_q <= 1'b1;
                first_q  <= (pulse_cnt_q == '0);
              end else begin
                state_q <= S_SKIP;
              end
            end
          end
          S_SKIP: begin
            if (trig_det) overrun_q <= 1'b1;
            skip_cnt_q <= skip_cnt_q - CNT_ONE;
            if (skip_cnt_q <= CNT_ONE) begin
              state_q  <= S_ACQ;
              acc_en_q <= 1'b1;
              first_q  <= (pulse_cnt_q == '0);
            end
          end
          S_ACQ: begin
            if (trig_det) overrun_q <= 1'b1;
            if (rb_last && pt_last) begin
              state_q     <= S_PEND;
              pulse_cnt_q <= pulse_cnt_q + CNT_ONE;
              acc_en_q    <= 1'b0;
              first_q     <= 1'b0;
              rb_q        <= '0;
              pt_q        <= '0;
            end else if (pt_last) begin
              pt_q <= '0;
              rb_q <= rb_q + IDX_ONE;
            end else begin
              pt_q <= pt_q + IDX_ONE;
            end
          end
          S_PEND: begin
            if (trig_det) overrun_q <= 1'b1;
            if (pulse_cnt_q == UR_nACC_Pulses) begin
              state_q    <= S_DONE;
              acc_done_q <= 1'b1;
            end else begin
              state_q <= S_ARM;
            end
          end
          S_DONE: begin
            if (rd_done) begin
              state_q    <= S_IDLE;
              upd_dis_q  <= 1'b0;
              busy_q     <= 1'b0;
              acc_done_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign CMD_Update_Disable = upd_dis_q;
  assign busy               = busy_q;
  assign acc_clear          = acc_clear_q;
  assign acc_en             = acc_en_q;
  assign first_pulse        = first_q;
  assign rb_index           = rb_q;
  assign pt_index           = pt_q;
  assign pulse_cnt          = pulse_cnt_q;
  assign acc_done           = acc_done_q;
  assign trig_overrun       = overrun_q;
  assign cfg_err            = cfg_err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: each run is predicted from its
// configuration (skip length, bins x points per pulse, pulse count) and traced cycle by cycle.
`timescale 1ns/1ps
module tb_acq_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] ur_cmd;
  logic [15:0] ur_mirror;
  logic [15:0] ur_nrb;
  logic [15:0] ur_npt;
  logic [15:0] ur_nacc;
  logic        trig_det;
  logic        rd_done;
  logic        cmd_dis;
  logic        busy;
  logic        acc_clear;
  logic        acc_en;
  logic        first_pulse;
  logic [15:0] rb_index;
  logic [15:0] pt_index;
  logic [15:0] pulse_cnt;
  logic        acc_done;
  logic        trig_overrun;
  logic        cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;
  bit exp_ovr;
  bit run_aborted;

  acq_sequencer #(.CNT_W(16), .IDX_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .UR_CMD            (ur_cmd),
    .UR_MirrorStart    (ur_mirror),
    .UR_nRangeBins     (ur_nrb),
    .UR_nPoints_RB     (ur_npt),
    .UR_nACC_Pulses    (ur_nacc),
    .trig_det          (trig_det),
    .rd_done           (rd_done),
    .CMD_Update_Disable(cmd_dis),
    .busy              (busy),
    .acc_clear         (acc_clear),
    .acc_en            (acc_en),
    .first_pulse       (first_pulse),
    .rb_index          (rb_index),
    .pt_index          (pt_index),
    .pulse_cnt         (pulse_cnt),
    .acc_done          (acc_done),
    .trig_overrun      (trig_overrun),
    .cfg_err           (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observe state 1 ns after each rising edge; inputs set here apply at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int hold);
    int extra;
    extra = 0;
    ur_cmd[0] = 1'b1;
    tick();
    tests_run++;
    if ({busy, cmd_dis, acc_clear, pulse_cnt, trig_overrun} !== {3'b111, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL start_accept busy=%b upd_dis=%b clr=%b pcnt=%0d ovr=%b exp 1 1 1 0 0",
               busy, cmd_dis, acc_clear, pulse_cnt, trig_overrun);
    end
    repeat (hold) begin
      tick();
      if (acc_clear) extra++;
    end
    ur_cmd[0] = 1'b0;
    tick();
    if (acc_clear) extra++;
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL acc_clear_once extra_pulses=%0d exp=0", extra);
    end
  endtask

  // One pulse: idle wait in ARM, trigger, expected skip, full bin/point sweep, PEND, then ARM/DONE.
  task automatic run_pulse(input int p, input int m, input int n, input int np,
                           input int a, input int ovr_k, input int abort_i);
    int gap;
    gap = $urandom_range(0, 4);
    for (int g = 0; g < gap; g++) begin
      tests_run++;
      if ({acc_en, busy, cmd_dis, acc_done} !== 4'b0110) begin
        tests_failed++;
        $display("FAIL arm_wait p=%0d en/busy/upd/done=%b%b%b%b exp=0110",
                 p, acc_en, busy, cmd_dis, acc_done);
      end
      tick();
    end
    trig_det = 1'b1;
    tick();
    trig_det = 1'b0;
    for (int i = 0; i < m; i++) begin
      tests_run++;
      if (acc_en !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL skip_phase p=%0d i=%0d acc_en=%b busy=%b exp 0 1", p, i, acc_en, busy);
      end
      if (i == abort_i) begin
        ur_cmd[1] = 1'b1;
        tick();
        ur_cmd[1] = 1'b0;
        tests_run++;
        if ({busy, acc_en, cmd_dis, acc_done, pulse_cnt} !== {4'b0000, 16'd0}) begin
          tests_failed++;
          $display("FAIL abort busy=%b en=%b upd=%b done=%b pcnt=%0d exp all 0",
                   busy, acc_en, cmd_dis, acc_done, pulse_cnt);
        end
        run_aborted = 1'b1;
        return;
      end
      tick();
    end
    for (int k = 0; k < n * np; k++) begin
      logic [15:0] erb, ept;
      erb = 16'(k / np);
      ept = 16'(k % np);
      tests_run++;
      if ({acc_en, rb_index, pt_index, first_pulse, pulse_cnt} !==
          {1'b1, erb, ept, (p == 0), 16'(p)}) begin
        tests_failed++;
        $display("FAIL acq_sample p=%0d k=%0d en=%b rb=%0d pt=%0d first=%b pcnt=%0d exp 1 %0d %0d %b %0d",
                 p, k, acc_en, rb_index, pt_index, first_pulse, pulse_cnt, erb, ept, (p == 0), p);
      end
      if (k == ovr_k) begin
        trig_det = 1'b1;
        exp_ovr  = 1'b1;
      end
      tick();
      trig_det = 1'b0;
    end
    tests_run++;
    if ({acc_en, first_pulse, rb_index, pt_index, pulse_cnt, trig_overrun} !==
        {2'b00, 16'd0, 16'd0, 16'(p + 1), exp_ovr}) begin
      tests_failed++;
      $display("FAIL pend p=%0d en=%b first=%b rb=%0d pt=%0d pcnt=%0d ovr=%b exp 0 0 0 0 %0d %b",
               p, acc_en, first_pulse, rb_index, pt_index, pulse_cnt, trig_overrun, p + 1, exp_ovr);
    end
    tick();
    tests_run++;
    if (acc_done !== (p + 1 == a) || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_pend p=%0d acc_done=%b busy=%b exp %b 1", p, acc_done, busy, (p + 1 == a));
    end
  endtask

  task automatic do_run(input int m, input int n, input int np, input int a,
                        input int ovr_p, input int ovr_k, input int abort_p, input int abort_i,
                        input int hold);
    int dwell;
    ur_mirror = 16'(m);
    ur_nrb    = 16'(n);
    ur_npt    = 16'(np);
    ur_nacc   = 16'(a);
    exp_ovr     = 1'b0;
    run_aborted = 1'b0;
    start_run(hold);
    for (int p = 0; p < a; p++) begin
      run_pulse(p, m, n, np, a, (p == ovr_p) ? ovr_k : -1, (p == abort_p) ? abort_i : -1);
      if (run_aborted) begin
        repeat (5) begin
          tick();
          tests_run++;
          if (acc_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_abort acc_done=%b busy=%b exp 0 0", acc_done, busy);
          end
        end
        return;
      end
    end
    dwell = $urandom_range(0, 3);
    for (int d = 0; d < dwell; d++) begin
      trig_det = (d == 0);
      tick();
      trig_det = 1'b0;
      tests_run++;
      if ({acc_done, busy, cmd_dis, acc_en} !== 4'b1110) begin
        tests_failed++;
        $display("FAIL done_hold done/busy/upd/en=%b%b%b%b exp=1110", acc_done, busy, cmd_dis, acc_en);
      end
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tests_run++;
    if ({busy, cmd_dis, acc_done, trig_overrun} !== {3'b000, exp_ovr}) begin
      tests_failed++;
      $display("FAIL readout busy=%b upd=%b done=%b ovr=%b exp 0 0 0 %b",
               busy, cmd_dis, acc_done, trig_overrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({cmd_dis, busy, acc_clear, acc_en, first_pulse, acc_done, trig_overrun, cfg_err,
         rb_index, pt_index, pulse_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state outputs not all zero (busy=%b upd=%b pcnt=%0d)", busy, cmd_dis, pulse_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    do_run(3, 2, 4, 2, -1, -1, -1, -1, 0);
  endtask

  task automatic test_mirror_zero();
    do_run(0, $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 2), -1, -1, -1, -1, 0);
  endtask

  task automatic test_cfg_err();
    for (int f = 0; f < 3; f++) begin
      ur_nrb  = (f == 0) ? 16'd0 : 16'd2;
      ur_npt  = (f == 1) ? 16'd0 : 16'd3;
      ur_nacc = (f == 2) ? 16'd0 : 16'd1;
      ur_cmd[0] = 1'b1;
      tick();
      tests_run++;
      if ({cfg_err, busy, cmd_dis, acc_clear} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL cfg_err field=%0d err/busy/upd/clr=%b%b%b%b exp=1000",
                 f, cfg_err, busy, cmd_dis, acc_clear);
      end
      tick();
      tests_run++;
      if ({cfg_err, busy, cmd_dis} !== 3'b000) begin
        tests_failed++;
        $display("FAIL cfg_err_once field=%0d err/busy/upd=%b%b%b exp=000", f, cfg_err, busy, cmd_dis);
      end
      ur_cmd[0] = 1'b0;
      tick();
    end
  endtask

  task automatic test_overrun();
    do_run(2, 2, 3, 3, 0, 2, -1, -1, 0);
  endtask

  task automatic test_abort();
    do_run(3, 2, 2, 3, -1, -1, 1, 1, 0);
    do_run(3, 2, 2, 3, -1, -1, -1, -1, 0);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++)
      do_run($urandom_range(0, 4), $urandom_range(1, 3), $urandom_range(1, 4),
             $urandom_range(1, 3), -1, -1, -1, -1, 0);
  endtask

  task automatic test_start_hold_and_reset();
    do_run(1, 2, 2, 2, -1, -1, -1, -1, 100);
    ur_mirror = 16'd2;
    ur_nrb    = 16'd3;
    ur_npt    = 16'd3;
    ur_nacc   = 16'd2;
    start_run(0);
    trig_det = 1'b1;
    tick();
    trig_det = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (acc_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_acq acc_en=%b exp=1", acc_en);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cmd_dis, busy, acc_clear, acc_en, first_pulse, acc_done, trig_overrun, cfg_err,
         rb_index, pt_index, pulse_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset busy=%b en=%b rb=%0d pt=%0d exp all 0", busy, acc_en, rb_index, pt_index);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({busy, acc_done, acc_en} !== 3'b000) begin
      tests_failed++;
      $display("FAIL post_reset busy=%b done=%b en=%b exp 000", busy, acc_done, acc_en);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ur_cmd    = 16'h0;
    ur_mirror = 16'd0;
    ur_nrb    = 16'd1;
    ur_npt    = 16'd1;
    ur_nacc   = 16'd1;
    trig_det  = 1'b0;
    rd_done   = 1'b0;
    test_reset();
    test_normal();
    test_mirror_zero();
    test_cfg_err();
    test_overrun();
    test_abort();
    test_random_runs();
    test_start_hold_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Controls one accumulation run of the lidar acquisition datapath, using the user-register fields decoded from the SPI command bank.
- Arms on a start command and waits for each laser trigger.
- Skips the mirror-start samples, then steps the accumulator through nRangeBins × nPoints_RB samples per pulse.
- Repeats for nACC_Pulses pulses, then hands the result to readout.
- Holds CMD_Update_Disable high while a run is in progress, so the register fields cannot change mid-run.

Parameters:
CNT_W, 16, width of all counters and config fields
IDX_W, 16, width of rb_index / pt_index outputs

Ports:
clk  in  1  system clock; one ADC sample per cycle
rst_n  in  1  reset, asynchronous, active-low
UR_CMD  in  16  bit0 = start (acted on at rising edge), bit1 = abort (level); other bits ignored
UR_MirrorStart  in  CNT_W  samples to skip after trigger
UR_nRangeBins  in  CNT_W  range bins per pulse
UR_nPoints_RB  in  CNT_W  samples per range bin
UR_nACC_Pulses  in  CNT_W  pulses to accumulate
trig_det  in  1  one-cycle trigger-detected pulse from the comparator
rd_done  in  1  readout-complete pulse from the host interface
CMD_Update_Disable  out  1  freezes the SPI command registers
busy  out  1  high in every state except IDLE
acc_clear  out  1  one-cycle pulse: clear accumulator memory
acc_en  out  1  current sample is accumulated
first_pulse  out  1  write the sample instead of adding it (first pulse of the run)
rb_index  out  IDX_W  current range-bin index
pt_index  out  IDX_W  point index within the bin
pulse_cnt  out  CNT_W  pulses completed in this run
acc_done  out  1  level, high in DONE
trig_overrun  out  1  sticky; a trigger arrived while a pulse was still being acquired
cfg_err  out  1  one-cycle pulse: start was rejected

Behaviour:
- Reset (rst_n low): all outputs 0, state IDLE, all counters 0, start-edge register 0.
- Start edge: UR_CMD[0] registered; start_evt = bit is 1 now and was 0 on the previous cycle.

States and transitions:
- IDLE:
  - On start_evt with UR_nRangeBins, UR_nPoints_RB and UR_nACC_Pulses all nonzero: pulse acc_clear, clear pulse_cnt and trig_overrun, go to ARM.
  - On start_evt with any of those three fields zero: pulse cfg_err, stay in IDLE.
- ARM: on trig_det, load skip_cnt = UR_MirrorStart.
  - If UR_MirrorStart is 0, go directly to ACQ.
  - Otherwise go to SKIP.
- SKIP: decrement skip_cnt each cycle; when skip_cnt reaches 1, go to ACQ next cycle. Exactly MirrorStart cycles are spent in SKIP.
- ACQ:
  - acc_en = 1 every cycle.
  - pt_index counts 0 … nPoints_RB−1, then wraps to 0 and rb_index increments.
  - After the last sample (rb_index = nRangeBins−1 and pt_index = nPoints_RB−1): increment pulse_cnt and go to PEND.
  - ACQ lasts exactly nRangeBins × nPoints_RB cycles.
  - first_pulse = 1 throughout ACQ when pulse_cnt = 0.
- PEND (one cycle): indexes return to 0.
  - If pulse_cnt = UR_nACC_Pulses, go to DONE.
  - Otherwise go to ARM.
- DONE: acc_done = 1; on rd_done, go to IDLE.

Outputs and counters:
- CMD_Update_Disable = 1 in ARM, SKIP, ACQ, PEND and DONE. It is registered and rises in the same cycle the state leaves IDLE, so config fields are stable for the whole run.
- acc_en, rb_index and pt_index are registered outputs. acc_en is high in the same cycle the corresponding sample is present (zero-latency alignment relative to state).
- A trig_det received while in SKIP, ACQ or PEND is ignored and sets trig_overrun.
- A trig_det received in IDLE or DONE is ignored silently.
- Abort: UR_CMD[1] = 1 in any non-IDLE state → IDLE on the next edge. acc_en drops immediately, counters reset, acc_done is not asserted.
- Abort has priority over start_evt, trig_det and rd_done arriving in the same cycle.
- A start_evt in any state other than IDLE is ignored.
- Counters are unsigned CNT_W bits; pulse_cnt never wraps because the run ends at nACC_Pulses.
- Asynchronous reset mid-run: immediate return to the reset state; no acc_done.

Test Plan:
1. Normal run: MirrorStart = 3, nRangeBins = 2, nPoints_RB = 4, nACC_Pulses = 2; start, then trig_det twice (20 cycles apart).
   - acc_clear pulses once.
   - Each pulse: acc_en high exactly 8 cycles, beginning 4 cycles after trig_det (3 SKIP cycles); rb_index/pt_index sequence (0,0)…(0,3),(1,0)…(1,3).
   - first_pulse high only during the first ACQ.
   - acc_done rises after the second PEND; rd_done returns to IDLE and CMD_Update_Disable falls.
2. MirrorStart = 0: acc_en rises 1 cycle after trig_det.
3. nPoints_RB = 0, then a start edge: cfg_err pulses once, state stays IDLE, CMD_Update_Disable stays 0.
4. trig_det during ACQ: trig_overrun goes to 1 and stays set; acc_en count for that pulse is unchanged; pulse_cnt increments only once.
5. Abort in the middle of SKIP of pulse 2: on the next edge busy = 0, acc_en = 0, pulse_cnt = 0, and acc_done never asserts. A later start edge runs a full, clean sequence.
6. UR_CMD[0] held high for 100 cycles: exactly one run starts. rst_n asserted during ACQ: all outputs 0 asynchronously.
